// File: rtl/mem_access_unit_if.sv
// Request/response handshake bundle between a requester and mem_access_unit.
// The unit sits on the slave side. The requester sits on the master side.
interface mem_access_unit_if;
   logic        req_valid;
   logic        req_ready;
   logic [1:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        resp_valid;
   logic        resp_ready;
   logic [31:0] resp_rdata;
   logic        resp_fault;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, resp_ready,
      input  req_ready, resp_valid, resp_rdata, resp_fault
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, resp_ready,
      output req_ready, resp_valid, resp_rdata, resp_fault
   );
endinterface

// File: rtl/mem_access_unit.sv
// Executes one LOAD/STORE/PUSH/POP at a time against a single-port word memory.
// It maintains a downward-growing stack whose pointer is exported on sp_out.
module mem_access_unit #(
   parameter int unsigned MEM_DEPTH   = 256,
   parameter logic [31:0] SP_INIT     = 32'd255,
   parameter int unsigned STACK_DEPTH = 16
) (
   input  logic             clock,
   input  logic             reset,
   mem_access_unit_if.slave bus,
   output logic [31:0]      sp_out,
   output logic [31:0]      AddressBus,
   output logic [31:0]      InputBus,
   input  logic [31:0]      OutputBus,
   output logic             sig_enable_write,
   output logic             sig_enable_read
);

   localparam int                 DEPTH_W   = $clog2(STACK_DEPTH + 1);
   localparam logic [31:0]        MEM_LIMIT = 32'(MEM_DEPTH);
   localparam logic [DEPTH_W-1:0] DEPTH_MAX = DEPTH_W'(STACK_DEPTH);
   localparam logic [DEPTH_W-1:0] DEPTH_ONE = DEPTH_W'(1);

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   typedef enum logic [1:0] {OP_LOAD, OP_STORE, OP_PUSH, OP_POP} op_t;

   state_t             state;
   state_t             state_next;
   op_t                op_q;
   op_t                req_op;
   logic [31:0]        sp;
   logic [DEPTH_W-1:0] depth;
   logic [31:0]        resp_rdata_q;
   logic               resp_fault_q;
   logic               req_fault;
   logic               accept;

   assign req_op = op_t'(bus.req_op);
   assign accept = (state == IDLE) && bus.req_valid;

   // A faulting request is resolved at acceptance and never touches memory.
   // The address check is a full 32-bit unsigned compare.
   always_comb begin
      req_fault = 1'b0;
      case (req_op)
         OP_LOAD, OP_STORE: req_fault = (bus.req_addr >= MEM_LIMIT);
         OP_PUSH:           req_fault = (depth == DEPTH_MAX);
         OP_POP:            req_fault = (depth == '0);
         default:           req_fault = 1'b0;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.req_valid) state_next = req_fault ? RESP : ACCESS;
         ACCESS:  state_next = RESP;
         RESP:    if (bus.resp_ready) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // The memory bus is registered on the acceptance edge, so the strobes are
   // high exactly during ACCESS. Stack and read-data updates happen on the
   // edge that leaves ACCESS.
   always_ff @(posedge clock) begin
      if (reset) begin
         op_q             <= OP_LOAD;
         sp               <= SP_INIT;
         depth            <= '0;
         resp_rdata_q     <= '0;
         resp_fault_q     <= 1'b0;
         AddressBus       <= '0;
         InputBus         <= '0;
         sig_enable_read  <= 1'b0;
         sig_enable_write <= 1'b0;
      end else begin
         sig_enable_read  <= 1'b0;
         sig_enable_write <= 1'b0;
         if (accept) begin
            op_q         <= req_op;
            resp_rdata_q <= '0;
            resp_fault_q <= req_fault;
            if (!req_fault) begin
               case (req_op)
                  OP_LOAD: begin
                     AddressBus      <= bus.req_addr;
                     sig_enable_read <= 1'b1;
                  end
                  OP_STORE: begin
                     AddressBus       <= bus.req_addr;
                     InputBus         <= bus.req_wdata;
                     sig_enable_write <= 1'b1;
                  end
                  OP_PUSH: begin
                     AddressBus       <= sp;
                     InputBus         <= bus.req_wdata;
                     sig_enable_write <= 1'b1;
                  end
                  OP_POP: begin
                     AddressBus      <= sp + 32'd1;
                     sig_enable_read <= 1'b1;
                  end
                  default: ;
               endcase
            end
         end
         if (state == ACCESS) begin
            case (op_q)
               OP_LOAD: resp_rdata_q <= OutputBus;
               OP_PUSH: begin
                  sp    <= sp - 32'd1;
                  depth <= depth + DEPTH_ONE;
               end
               OP_POP: begin
                  resp_rdata_q <= OutputBus;
                  sp           <= sp + 32'd1;
                  depth        <= depth - DEPTH_ONE;
               end
               default: ;
            endcase
         end
      end
   end

   assign bus.req_ready  = (state == IDLE);
   assign bus.resp_valid = (state == RESP);
   assign bus.resp_rdata = resp_rdata_q;
   assign bus.resp_fault = resp_fault_q;
   assign sp_out         = sp;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit against a 256-word memory model.
// It covers the load, store and stack paths, faults, backpressure and reset aborts.
module tb_mem_access_unit;

   localparam logic [1:0] LOAD_OP  = 2'd0;
   localparam logic [1:0] STORE_OP = 2'd1;
   localparam logic [1:0] PUSH_OP  = 2'd2;
   localparam logic [1:0] POP_OP   = 2'd3;

   logic        clock = 1'b0;
   logic        reset;
   logic [31:0] sp_out;
   logic [31:0] AddressBus;
   logic [31:0] InputBus;
   logic [31:0] OutputBus;
   logic        sig_enable_write;
   logic        sig_enable_read;
   logic [31:0] mem [0:255];

   typedef struct packed {
      logic [31:0] rdata;
      logic        fault;
   } resp_t;

   resp_t expQ[$];
   int    checkCount = 0;
   int    passCount  = 0;
   int    failCount  = 0;

   mem_access_unit_if bus();

   mem_access_unit dut (
      .clock            (clock),
      .reset            (reset),
      .bus              (bus),
      .sp_out           (sp_out),
      .AddressBus       (AddressBus),
      .InputBus         (InputBus),
      .OutputBus        (OutputBus),
      .sig_enable_write (sig_enable_write),
      .sig_enable_read  (sig_enable_read)
   );

   always #5 clock = ~clock;

   // The memory model reads combinationally under the read strobe and writes on the clock edge.
   assign OutputBus = sig_enable_read ? mem[AddressBus[7:0]] : 32'd0;

   always @(posedge clock) begin
      if (sig_enable_write) mem[AddressBus[7:0]] <= InputBus;
   end

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      assert (observed === expected) passCount++;
      else begin
         failCount++;
         $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
      end
   endtask

   task automatic checkOutput(input logic [31:0] expSp);
      resp_t exp;
      check("resp_valid", bus.resp_valid, 1'b1);
      check("strobes_idle", {sig_enable_read, sig_enable_write}, 2'b00);
      if (expQ.size() == 0) begin
         check("scoreboard_nonempty", expQ.size(), 1);
      end else begin
         exp = expQ.pop_front();
         check("resp_rdata", bus.resp_rdata, exp.rdata);
         check("resp_fault", bus.resp_fault, exp.fault);
      end
      check("sp_out", sp_out, expSp);
   endtask

   task automatic applyStimulus(input logic [1:0] op, input logic [31:0] addr, input logic [31:0] wdata,
                                input logic expFault, input logic [31:0] expRdata,
                                input logic [31:0] expAddr, input logic [31:0] expSp);
      logic isRead;
      isRead = (op == LOAD_OP) || (op == POP_OP);
      @(negedge clock);
      check("req_ready_idle", bus.req_ready, 1'b1);
      bus.req_valid = 1'b1;
      bus.req_op    = op;
      bus.req_addr  = addr;
      bus.req_wdata = wdata;
      expQ.push_back('{rdata: expRdata, fault: expFault});
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      bus.req_addr  = 32'hFFFF_FFFF;
      bus.req_wdata = 32'h0;
      if (!expFault) begin
         @(negedge clock);
         check("access_read", sig_enable_read, isRead);
         check("access_write", sig_enable_write, !isRead);
         check("access_addr", AddressBus, expAddr);
         if (!isRead) check("access_wdata", InputBus, wdata);
         check("access_no_resp", bus.resp_valid, 1'b0);
         check("access_not_ready", bus.req_ready, 1'b0);
         @(posedge clock);
      end
      @(negedge clock);
      checkOutput(expSp);
   endtask

   task automatic releaseResponse();
      bus.resp_ready = 1'b1;
      @(posedge clock);
      #1;
      bus.resp_ready = 1'b0;
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'd0;
      mem[0] = 32'd10;
      reset          = 1'b1;
      bus.req_valid  = 1'b0;
      bus.req_op     = LOAD_OP;
      bus.req_addr   = 32'd0;
      bus.req_wdata  = 32'd0;
      bus.resp_ready = 1'b0;
      repeat (3) @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("rst_req_ready", bus.req_ready, 1'b1);
      check("rst_resp_valid", bus.resp_valid, 1'b0);
      check("rst_sp", sp_out, 32'd255);
      check("rst_bus", {AddressBus, InputBus}, 64'd0);
      check("rst_strobes", {sig_enable_read, sig_enable_write}, 2'b00);

      applyStimulus(LOAD_OP, 32'd0, 32'd0, 1'b0, 32'd10, 32'd0, 32'd255);
      releaseResponse();
      applyStimulus(STORE_OP, 32'd7, 32'hDEADBEEF, 1'b0, 32'd0, 32'd7, 32'd255);
      releaseResponse();
      applyStimulus(LOAD_OP, 32'd7, 32'd0, 1'b0, 32'hDEADBEEF, 32'd7, 32'd255);
      releaseResponse();

      applyStimulus(PUSH_OP, 32'd0, 32'h11, 1'b0, 32'd0, 32'd255, 32'd254);
      releaseResponse();
      applyStimulus(PUSH_OP, 32'd0, 32'h22, 1'b0, 32'd0, 32'd254, 32'd253);
      releaseResponse();
      applyStimulus(LOAD_OP, 32'd255, 32'd0, 1'b0, 32'h11, 32'd255, 32'd253);
      releaseResponse();
      applyStimulus(POP_OP, 32'd0, 32'd0, 1'b0, 32'h22, 32'd254, 32'd254);
      releaseResponse();
      applyStimulus(POP_OP, 32'd0, 32'd0, 1'b0, 32'h11, 32'd255, 32'd255);
      releaseResponse();

      applyStimulus(POP_OP, 32'd0, 32'd0, 1'b1, 32'd0, 32'd0, 32'd255);
      releaseResponse();
      applyStimulus(LOAD_OP, 32'd256, 32'd0, 1'b1, 32'd0, 32'd0, 32'd255);
      releaseResponse();
      applyStimulus(STORE_OP, 32'h8000_0000, 32'h5, 1'b1, 32'd0, 32'd0, 32'd255);
      releaseResponse();

      for (int i = 0; i < 16; i++) begin
         applyStimulus(PUSH_OP, 32'd0, 32'h100 + 32'(i), 1'b0, 32'd0, 32'd255 - 32'(i), 32'd254 - 32'(i));
         releaseResponse();
      end
      applyStimulus(PUSH_OP, 32'd0, 32'h999, 1'b1, 32'd0, 32'd0, 32'd239);
      releaseResponse();
      check("full_depth", 32'(dut.depth), 32'd16);
      applyStimulus(POP_OP, 32'd0, 32'd0, 1'b0, 32'h10F, 32'd240, 32'd240);
      releaseResponse();

      applyStimulus(LOAD_OP, 32'd7, 32'd0, 1'b0, 32'hDEADBEEF, 32'd7, 32'd240);
      for (int i = 0; i < 5; i++) begin
         @(negedge clock);
         check("hold_valid", bus.resp_valid, 1'b1);
         check("hold_rdata", bus.resp_rdata, 32'hDEADBEEF);
      end
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("abort_resp_ready", bus.req_ready, 1'b1);
      check("abort_resp_valid", bus.resp_valid, 1'b0);
      check("abort_resp_sp", sp_out, 32'd255);
      check("abort_resp_depth", 32'(dut.depth), 32'd0);

      @(negedge clock);
      bus.req_valid = 1'b1;
      bus.req_op    = PUSH_OP;
      bus.req_wdata = 32'h77;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      @(negedge clock);
      check("abort_push_write", sig_enable_write, 1'b1);
      reset = 1'b1;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      check("abort_push_sp", sp_out, 32'd255);
      check("abort_push_depth", 32'(dut.depth), 32'd0);
      check("abort_push_valid", bus.resp_valid, 1'b0);
      check("abort_push_strobes", {sig_enable_read, sig_enable_write}, 2'b00);

      applyStimulus(LOAD_OP, 32'd0, 32'd0, 1'b0, 32'd10, 32'd0, 32'd255);
      releaseResponse();
      check("scoreboard_empty", expQ.size(), 0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 The block SHALL take parameter MEM_DEPTH, default 256: number of 32-bit words in the attached data memory.
REQ-002 The block SHALL take parameter SP_INIT, default 255: stack pointer value after reset.
REQ-003 The block SHALL take parameter STACK_DEPTH, default 16: maximum number of words on the stack.
REQ-004 The block SHALL have port clock, input, 1 bit: the only clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port req_valid, input, 1 bit: a request is presented.
REQ-007 The block SHALL have port req_ready, output, 1 bit: a request can be accepted.
REQ-008 The block SHALL have port req_op, input, 2 bits: operation code, 0=LOAD, 1=STORE, 2=PUSH, 3=POP.
REQ-009 The block SHALL have port req_addr, input, 32 bits: word address for LOAD/STORE; ignored for PUSH/POP.
REQ-010 The block SHALL have port req_wdata, input, 32 bits: write data for STORE/PUSH.
REQ-011 The block SHALL have port resp_valid, output, 1 bit: a response is presented.
REQ-012 The block SHALL have port resp_ready, input, 1 bit: the consumer accepts the response.
REQ-013 The block SHALL have port resp_rdata, output, 32 bits: read data for LOAD/POP; 0 otherwise.
REQ-014 The block SHALL have port resp_fault, output, 1 bit: the request was rejected without any memory access.
REQ-015 The block SHALL have port sp_out, output, 32 bits: current stack pointer.
REQ-016 The block SHALL have port AddressBus, output, 32 bits: memory word address.
REQ-017 The block SHALL have port InputBus, output, 32 bits: memory write data.
REQ-018 The block SHALL have port OutputBus, input, 32 bits: memory read data, valid combinationally while sig_enable_read=1.
REQ-019 The block SHALL have ports sig_enable_write and sig_enable_read, outputs, 1 bit each: memory strobes.

Function
REQ-020 The block SHALL implement a state machine with states IDLE, ACCESS and RESP.
REQ-021 In IDLE, req_ready SHALL be 1; in every other state it SHALL be 0.
REQ-022 A request SHALL be accepted on an edge where state is IDLE and req_valid=1; op, address and data SHALL be latched on that edge.
REQ-023 On acceptance of a non-faulting request, the next state SHALL be ACCESS, lasting exactly one cycle, followed by RESP.
REQ-024 On acceptance of a faulting request, the next state SHALL be RESP with resp_fault=1 and resp_rdata=0, with no strobe and no SP or depth change.
REQ-025 Latency SHALL be: accept at edge N; ACCESS during cycle N+1; resp_valid=1 from cycle N+2 (fault: from cycle N+1).
REQ-026 In RESP, resp_valid SHALL be 1, resp_rdata and resp_fault SHALL be held stable, and the state SHALL return to IDLE on the edge where resp_ready=1.
REQ-027 AddressBus, InputBus and the strobes SHALL be registered outputs, updated on the same edge that enters ACCESS.
REQ-028 During ACCESS, exactly one strobe SHALL be 1: sig_enable_read for LOAD/POP, sig_enable_write for STORE/PUSH.
REQ-029 Outside ACCESS, both strobes SHALL be 0, and they SHALL never be 1 simultaneously.
REQ-030 For LOAD, AddressBus SHALL equal req_addr, and OutputBus SHALL be captured into resp_rdata on the edge leaving ACCESS.
REQ-031 LOAD and STORE SHALL fault if req_addr >= MEM_DEPTH; the comparison SHALL be full 32-bit unsigned.
REQ-032 For STORE, AddressBus SHALL equal req_addr and InputBus SHALL equal req_wdata.
REQ-033 PUSH SHALL drive AddressBus=SP and InputBus=req_wdata, then SP<=SP-1 and depth<=depth+1 on the edge leaving ACCESS.
REQ-034 PUSH SHALL fault when depth==STACK_DEPTH.
REQ-035 POP SHALL drive AddressBus=SP+1 and capture OutputBus, then SP<=SP+1 and depth<=depth-1 on the edge leaving ACCESS.
REQ-036 POP SHALL fault when depth==0.
REQ-037 SP arithmetic SHALL be 32-bit modulo, and sp_out SHALL equal the current SP register.
REQ-038 When not in IDLE, req_valid SHALL be ignored; no request SHALL be queued or lost, since the requester holds it until req_ready=1.

Reset
REQ-039 While reset=1 at an edge, the next state SHALL be IDLE, both strobes SHALL be 0, resp_valid=0, resp_fault=0, resp_rdata=0, AddressBus=0, InputBus=0, SP=SP_INIT and depth=0.
REQ-040 Reset SHALL take priority over all requests and handshakes.
REQ-041 Reset asserted in ACCESS or RESP SHALL abort the operation: a pending response SHALL be dropped, and an aborted PUSH/POP SHALL leave SP=SP_INIT.

Verification
REQ-042 The bench SHALL cover LOAD addr 0 with memory preloaded 10: strobes read for one cycle with AddressBus=0; resp_valid at N+2 with rdata=10 and fault=0.
REQ-043 The bench SHALL cover STORE addr 7 data 0xDEADBEEF followed by LOAD 7: one-cycle write strobe; the load returns 0xDEADBEEF.
REQ-044 The bench SHALL cover PUSH 0x11, PUSH 0x22, POP, POP: writes at 255 then 254; sp_out goes 253, then 254, then 255; pops return 0x22 then 0x11.
REQ-045 The bench SHALL cover POP on an empty stack and LOAD at address 256: resp_fault=1 and rdata=0 at N+1, no strobe, SP unchanged.
REQ-046 The bench SHALL cover 17 consecutive PUSHes: the first 16 succeed and the 17th faults, with sp_out=239 and depth=16.
REQ-047 The bench SHALL cover resp_ready held 0 for 5 cycles, then reset asserted in RESP: rdata stays stable while waiting; after reset, IDLE with req_ready=1, resp_valid=0, and sp_out=255.
